// File: rtl/uart_frame_ctrl_if.sv
// Bus bundle between the UART byte source and the frame controller.
// Handshake: rx_data_vld is a one-cycle strobe with no back-pressure; rx_data
// is valid only in a cycle where rx_data_vld is high. There is no ready, so a
// byte offered while the controller is writing is discarded and reported on
// drop. All controller outputs are registered pulses or levels. wr_addr and
// wr_data are meaningful only when wr_en is high. state_dbg mirrors the FSM
// state so that checkers can bind to it.
interface uart_frame_ctrl_if;
  logic       rx_data_vld;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       frame_ok;
  logic       frame_err;
  logic       timeout;
  logic       drop;
  logic [2:0] state_dbg;

  modport master (
    output rx_data_vld, rx_data,
    input  wr_en, wr_addr, wr_data, busy, frame_ok, frame_err, timeout, drop,
    input  state_dbg
  );

  modport slave (
    input  rx_data_vld, rx_data,
    output wr_en, wr_addr, wr_data, busy, frame_ok, frame_err, timeout, drop,
    output state_dbg
  );
endinterface

// File: rtl/uart_frame_ctrl.sv
// Command-frame parser behind the UART receiver.
// Frame: HEADER, base address, length, payload[length], checksum, where the
// checksum is the 8-bit sum of address, length and payload bytes. A good frame
// is replayed from the buffer as back-to-back register writes.
module uart_frame_ctrl #(
  parameter int unsigned CLOCK         = 50_000_000,
  parameter int unsigned BAUD          = 9600,
  parameter logic [7:0]  HEADER        = 8'h55,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_BYTES = 3
) (
  input logic              clk,
  input logic              rst,
  uart_frame_ctrl_if.slave bus
);

  localparam int unsigned BIT_CYC = CLOCK / BAUD;
  localparam int unsigned TO_CYC  = TIMEOUT_BYTES * 10 * BIT_CYC;
  localparam int          CW      = $clog2(TO_CYC + 1);
  localparam int          IW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CSUM  = 3'd4,
    S_WRITE = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      base_q, len_q, idx_q, widx_q, sum_q;
  logic [CW-1:0]   cnt_q;
  logic [7:0]      buf_mem [MAX_LEN];

  logic            wr_en_q, busy_q, frame_ok_q, frame_err_q, timeout_q, drop_q;
  logic [7:0]      wr_addr_q, wr_data_q;
  logic            wr_en_d, frame_ok_d, frame_err_d, timeout_d, drop_d;
  logic [7:0]      wr_addr_d, wr_data_d;

  logic            byte_in, framing, to_hit, len_ok, csum_ok, last_data, more_beats;

  assign byte_in    = bus.rx_data_vld;
  assign framing    = (state_q == S_ADDR) || (state_q == S_LEN) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);
  // A byte in the expiry cycle wins, so expiry is only acted on without one.
  assign to_hit     = framing && !byte_in && (cnt_q == CW'(TO_CYC - 1));
  assign len_ok     = (bus.rx_data <= 8'(MAX_LEN));
  assign csum_ok    = (bus.rx_data == sum_q);
  assign last_data  = (idx_q == (len_q - 8'd1));
  assign more_beats = (widx_q < len_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: parse one byte per strobe, bail out on timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (byte_in && bus.rx_data == HEADER) state_d = S_ADDR;
      S_ADDR:  if (byte_in) state_d = S_LEN;
               else if (to_hit) state_d = S_IDLE;
      S_LEN:   if (byte_in) begin
                 if (bus.rx_data == 8'd0) state_d = S_CSUM;
                 else if (len_ok)         state_d = S_DATA;
                 else                     state_d = S_IDLE;
               end else if (to_hit) state_d = S_IDLE;
      S_DATA:  if (byte_in) begin
                 if (last_data) state_d = S_CSUM;
               end else if (to_hit) state_d = S_IDLE;
      S_CSUM:  if (byte_in) begin
                 if (csum_ok && len_q != 8'd0) state_d = S_WRITE;
                 else                          state_d = S_IDLE;
               end else if (to_hit) state_d = S_IDLE;
      S_WRITE: if (!more_beats) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. Beat 0 is launched
  // from the checksum cycle so the first write lands the cycle after it.
  always_comb begin
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = to_hit;
    drop_d      = 1'b0;
    case (state_q)
      S_LEN:   if (byte_in && !len_ok) frame_err_d = 1'b1;
      S_CSUM:  if (byte_in) begin
                 if (csum_ok) begin
                   frame_ok_d = 1'b1;
                   if (len_q != 8'd0) begin
                     wr_en_d   = 1'b1;
                     wr_addr_d = base_q;
                     wr_data_d = buf_mem[0];
                   end
                 end else begin
                   frame_err_d = 1'b1;
                 end
               end
      S_WRITE: begin
                 drop_d = byte_in;
                 if (more_beats) begin
                   wr_en_d   = 1'b1;
                   wr_addr_d = base_q + widx_q;
                   wr_data_d = buf_mem[widx_q[IW-1:0]];
                 end
               end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      base_q      <= 8'd0;
      len_q       <= 8'd0;
      idx_q       <= 8'd0;
      widx_q      <= 8'd0;
      sum_q       <= 8'd0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      wr_addr_q   <= 8'd0;
      wr_data_q   <= 8'd0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      if (framing && !byte_in && !to_hit) cnt_q <= cnt_q + 1'b1;
      else                                cnt_q <= '0;
      if (byte_in) begin
        case (state_q)
          S_ADDR: begin base_q <= bus.rx_data; sum_q <= bus.rx_data; end
          S_LEN:  begin len_q <= bus.rx_data; idx_q <= 8'd0; sum_q <= sum_q + bus.rx_data; end
          S_DATA: begin idx_q <= idx_q + 8'd1; sum_q <= sum_q + bus.rx_data; end
          default: ;
        endcase
      end
      if (state_q == S_CSUM && byte_in && csum_ok)  widx_q <= 8'd1;
      else if (state_q == S_WRITE && more_beats)     widx_q <= widx_q + 8'd1;
      wr_en_q     <= wr_en_d;
      busy_q      <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
      drop_q      <= drop_d;
    end
  end

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (state_q == S_DATA && byte_in) buf_mem[idx_q[IW-1:0]] <= bus.rx_data;
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = busy_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.timeout   = timeout_q;
  assign bus.drop      = drop_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl (CLOCK=1000, BAUD=100 -> 300-cycle timeout).
module tb_uart_frame_ctrl;

  logic clk;
  logic rst;
  uart_frame_ctrl_if bus();

  uart_frame_ctrl #(
    .CLOCK(1000), .BAUD(100), .HEADER(8'h55), .MAX_LEN(16), .TIMEOUT_BYTES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  int ok_cnt = 0, err_cnt = 0, to_cnt = 0, drop_cnt = 0, wr_cnt = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_counts();
    ok_cnt = 0; err_cnt = 0; to_cnt = 0; drop_cnt = 0; wr_cnt = 0;
  endtask

  // Monitor: count pulses and compare every write against the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.frame_ok)  ok_cnt++;
      if (bus.frame_err) err_cnt++;
      if (bus.timeout)   to_cnt++;
      if (bus.drop)      drop_cnt++;
      if (bus.wr_en || bus.busy) check("busy_eq_wr_en", bus.busy, bus.wr_en);
      if (bus.wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", {bus.wr_addr, bus.wr_data}, 16'hxxxx);
        end else begin
          mon_e = exp_q.pop_front();
          check("write_addr_data", {bus.wr_addr, bus.wr_data}, mon_e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data_vld = 1'b1;
    bus.rx_data     = b;
    @(negedge clk);
    bus.rx_data_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  b [12];
    int          n;
    int          exp_ok;
    int          exp_err;
    int          nw;
    logic [15:0] w [3];
  } vec_t;

  vec_t vec [7];

  initial begin
    vec[0].b = '{8'h55,8'h10,8'h03,8'hAA,8'hBB,8'hCC,8'h44,0,0,0,0,0};
    vec[0].n = 7; vec[0].exp_ok = 1; vec[0].exp_err = 0; vec[0].nw = 3;
    vec[0].w = '{16'h10AA, 16'h11BB, 16'h12CC};
    vec[1].b = '{8'h55,8'hFF,8'h02,8'h01,8'h02,8'h04,0,0,0,0,0,0};
    vec[1].n = 6; vec[1].exp_ok = 1; vec[1].exp_err = 0; vec[1].nw = 2;
    vec[1].w = '{16'hFF01, 16'h0002, 16'h0000};
    vec[2].b = '{8'h55,8'h10,8'h03,8'hAA,8'hBB,8'hCC,8'h45,0,0,0,0,0};
    vec[2].n = 7; vec[2].exp_ok = 0; vec[2].exp_err = 1; vec[2].nw = 0;
    vec[2].w = '{16'h0, 16'h0, 16'h0};
    vec[3].b = '{8'h55,8'h20,8'h00,8'h20,0,0,0,0,0,0,0,0};
    vec[3].n = 4; vec[3].exp_ok = 1; vec[3].exp_err = 0; vec[3].nw = 0;
    vec[3].w = '{16'h0, 16'h0, 16'h0};
    vec[4].b = '{8'h55,8'h10,8'h11,0,0,0,0,0,0,0,0,0};
    vec[4].n = 3; vec[4].exp_ok = 0; vec[4].exp_err = 1; vec[4].nw = 0;
    vec[4].w = '{16'h0, 16'h0, 16'h0};
    vec[5].b = '{8'h00,8'hAA,8'h55,8'h30,8'h01,8'h7E,8'hAF,0,0,0,0,0};
    vec[5].n = 7; vec[5].exp_ok = 1; vec[5].exp_err = 0; vec[5].nw = 1;
    vec[5].w = '{16'h307E, 16'h0, 16'h0};
    vec[6].b = '{8'h55,8'h40,8'h01,8'h00,8'h41,0,0,0,0,0,0,0};
    vec[6].n = 5; vec[6].exp_ok = 1; vec[6].exp_err = 0; vec[6].nw = 1;
    vec[6].w = '{16'h4000, 16'h0, 16'h0};
  end

  // ---------------- main sequence ----------------
  int cyc;
  bit seen;

  initial begin
    rst = 1'b1;
    bus.rx_data_vld = 1'b0;
    bus.rx_data = 8'h00;
    idle(3);
    check("reset_outputs", {bus.wr_en, bus.busy, bus.frame_ok, bus.frame_err,
                            bus.timeout, bus.drop, bus.wr_addr, bus.wr_data}, 32'h0);
    check("reset_state", bus.state_dbg, 3'd0);
    rst = 1'b0;
    idle(2);

    // Good frame with exact write timing and a byte dropped during WRITE.
    clear_counts();
    exp_q.push_back(16'h10AA); exp_q.push_back(16'h11BB); exp_q.push_back(16'h12CC);
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'h44);
    check("t1_frame_ok_next_cycle", bus.frame_ok, 1'b1);
    check("t1_beat0", {bus.wr_en, bus.busy, bus.wr_addr}, {1'b1, 1'b1, 8'h10});
    bus.rx_data_vld = 1'b1; bus.rx_data = 8'h55;
    @(negedge clk);
    bus.rx_data_vld = 1'b0;
    check("t1_drop_pulse", bus.drop, 1'b1);
    check("t1_beat1", {bus.wr_en, bus.wr_addr, bus.wr_data}, {1'b1, 8'h11, 8'hBB});
    @(negedge clk);
    check("t1_beat2", {bus.wr_en, bus.drop, bus.wr_addr}, {1'b1, 1'b0, 8'h12});
    @(negedge clk);
    check("t1_write_done", {bus.wr_en, bus.busy}, 2'b00);
    check("t1_state_idle", bus.state_dbg, 3'd0);
    check("t1_hold_addr_data", {bus.wr_addr, bus.wr_data}, 16'h12CC);
    idle(3);
    check("t1_counts", {ok_cnt[7:0], err_cnt[7:0], drop_cnt[7:0], wr_cnt[7:0]}, 32'h01000103);
    check("t1_queue_empty", exp_q.size(), 0);

    // Reset during the second beat.
    exp_q.push_back(16'h10AA); exp_q.push_back(16'h11BB); exp_q.push_back(16'h12CC);
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'h44);
    @(negedge clk);
    check("rst_second_beat_seen", {bus.wr_en, bus.wr_addr}, {1'b1, 8'h11});
    #2 rst = 1'b1;
    #1;
    check("rst_async_outputs", {bus.wr_en, bus.busy, bus.frame_ok, bus.frame_err,
                                bus.timeout, bus.drop, bus.wr_addr, bus.wr_data}, 32'h0);
    check("rst_async_state", bus.state_dbg, 3'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    idle(2);

    // Timeout after 55 10 03 with a silent line.
    clear_counts();
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h03);
    cyc = 0; seen = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.timeout) seen = 1;
    end
    check("to_pulse_seen", seen, 1'b1);
    check("to_latency_cycles", cyc, 300);
    check("to_state_idle", bus.state_dbg, 3'd0);
    idle(2);
    check("to_single_pulse", {to_cnt[7:0], ok_cnt[7:0], err_cnt[7:0]}, 24'h010000);

    // Byte landing in the last cycle before expiry keeps the frame alive.
    clear_counts();
    exp_q.push_back(16'h10AA); exp_q.push_back(16'h11BB); exp_q.push_back(16'h12CC);
    send_byte(8'h55); send_byte(8'h10); send_byte(8'h03);
    idle(298);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'h44);
    idle(6);
    check("to_edge_no_timeout", to_cnt, 0);
    check("to_edge_frame_ok", ok_cnt, 1);
    check("to_edge_writes", wr_cnt, 3);

    // Maximum payload length: 16 bytes at base 0x00.
    clear_counts();
    send_byte(8'h55); send_byte(8'h00); send_byte(8'h10);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back({8'(k), 8'(k + 1)});
      send_byte(8'(k + 1));
    end
    send_byte(8'h98);
    idle(20);
    check("maxlen_frame_ok", ok_cnt, 1);
    check("maxlen_writes", wr_cnt, 16);
    check("maxlen_queue_empty", exp_q.size(), 0);

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      clear_counts();
      for (int j = 0; j < vec[v].nw; j++) exp_q.push_back(vec[v].w[j]);
      for (int j = 0; j < vec[v].n; j++) send_byte(vec[v].b[j]);
      idle(10);
      check($sformatf("vec%0d_frame_ok", v), ok_cnt, vec[v].exp_ok);
      check($sformatf("vec%0d_frame_err", v), err_cnt, vec[v].exp_err);
      check($sformatf("vec%0d_writes", v), wr_cnt, vec[v].nw);
      check($sformatf("vec%0d_queue_empty", v), exp_q.size(), 0);
      check($sformatf("vec%0d_no_timeout_drop", v), to_cnt + drop_cnt, 0);
      check($sformatf("vec%0d_state_idle", v), bus.state_dbg, 3'd0);
      exp_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
